// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: paces requests to a multi-cycle instruction memory,
// gates PC/IF-ID updates and parks a taken branch that resolves mid-fetch.
module fetch_sequencer #(
  parameter int WORD_LENGTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   br_taken,
  input  logic [WORD_LENGTH-1:0] br_offset,
  input  logic                   haz_det,
  input  logic                   imem_ready,
  output logic                   imem_req,
  output logic                   pc_write_en,
  output logic                   br_sel,
  output logic [WORD_LENGTH-1:0] br_offset_out,
  output logic                   if_id_write_en,
  output logic                   if_id_flush,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   pend_valid_reg, pend_valid_next;
  logic [WORD_LENGTH-1:0] pend_offset_reg, pend_offset_next;
  logic [CNT_WIDTH-1:0]   stall_cycles_reg;

  logic req_c, pc_write_c, sel_c, if_id_write_c, flush_c;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      pend_valid_reg   <= 1'b0;
      pend_offset_reg  <= '0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_valid_reg  <= pend_valid_next;
      pend_offset_reg <= pend_offset_next;
      if (!pc_write_c && (stall_cycles_reg != {CNT_WIDTH{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pend_valid_next  = pend_valid_reg;
    pend_offset_next = pend_offset_reg;
    req_c            = 1'b0;
    pc_write_c       = 1'b0;
    sel_c            = 1'b0;
    if_id_write_c    = 1'b0;
    flush_c          = br_taken;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        if (br_taken) begin
          pc_write_c = 1'b1;
          sel_c      = 1'b1;
        end
      end
      FETCH: begin
        req_c = 1'b1;
        if (imem_ready) begin
          // A parked or same-cycle branch wins over the returning instruction.
          if (br_taken || pend_valid_reg) begin
            flush_c         = 1'b1;
            pc_write_c      = 1'b1;
            sel_c           = 1'b1;
            pend_valid_next = 1'b0;
          end else if (!haz_det) begin
            if_id_write_c = 1'b1;
            pc_write_c    = 1'b1;
          end else begin
            state_next = STALL;
          end
        end else if (br_taken) begin
          pend_valid_next  = 1'b1;
          pend_offset_next = br_offset;
        end
      end
      STALL: begin
        if (br_taken) begin
          pc_write_c = 1'b1;
          sel_c      = 1'b1;
          state_next = FETCH;
        end else if (!haz_det) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if inputs are active.
  assign imem_req       = reset & req_c;
  assign pc_write_en    = reset & pc_write_c;
  assign br_sel         = reset & sel_c;
  assign if_id_write_en = reset & if_id_write_c;
  assign if_id_flush    = reset & flush_c;
  assign br_offset_out  = !reset ? '0 : (br_taken ? br_offset : pend_offset_reg);
  assign stall_cycles   = stall_cycles_reg;
  assign state          = state_reg;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the IF stage against a multi-cycle instruction memory. It issues fetch requests and gates the PC register write-enable and the branch-offset adder select. It also drives IF/ID load/flush, and holds a taken branch that resolves while a fetch is in flight. It sits between the ID hazard unit, the branch-resolve stage, the instruction memory and the IF datapath (PC register, offset mux, PC adder).

Parameters:
WORD_LENGTH, 32, width of branch offset path
CNT_WIDTH, 16, width of stall-cycle performance counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
br_taken  input  1  one-cycle pulse: branch resolved taken
br_offset  input  WORD_LENGTH  word offset, valid only when br_taken=1
haz_det  input  1  ID-stage hazard stall request
imem_ready  input  1  instruction data valid this cycle
imem_req  output  1  fetch request to instruction memory
pc_write_en  output  1  PC register write-enable
br_sel  output  1  IF adder input select: 1 = offset<<2, 0 = 4
br_offset_out  output  WORD_LENGTH  offset to IF offset mux
if_id_write_en  output  1  load fetched instruction into IF/ID
if_id_flush  output  1  load bubble into IF/ID
stall_cycles  output  CNT_WIDTH  saturating count of cycles with pc_write_en=0
state  output  2  debug: 0 IDLE, 1 FETCH, 2 STALL

Behaviour:
- Reset (reset=0, async): state=IDLE, pend_valid=0, pend_offset=0, stall_cycles=0. All 1-bit outputs 0; br_offset_out=0.
- br_offset_out = br_taken ? br_offset : pend_offset (combinational).
- br_sel = 1 only in a redirect cycle. It is always paired with pc_write_en=1.
- IDLE: imem_req=0. Next cycle goes to FETCH. br_taken in IDLE: redirect this cycle, then FETCH.
- FETCH: imem_req=1, held until imem_ready. imem_ready is ignored when imem_req=0.
  - imem_ready, no branch (pend_valid=0, br_taken=0), haz_det=0: if_id_write_en=1, pc_write_en=1, br_sel=0. Stay in FETCH; the next request starts next cycle.
  - imem_ready, no branch, haz_det=1: instruction dropped, no PC write, if_id_write_en=0, go to STALL.
  - br_taken without imem_ready: if_id_flush=1. Latch pend_offset<=br_offset and pend_valid<=1. Stay in FETCH. The outstanding request completes.
  - imem_ready with pend_valid=1 or br_taken=1: returning instruction discarded. if_id_flush=1, pc_write_en=1, br_sel=1, clear pend_valid. Stay in FETCH.
  - br_taken while pend_valid=1: new offset overwrites pend_offset.
- STALL: imem_req=0, no PC write. haz_det=0 goes to FETCH, which re-fetches the same PC.
  - br_taken in STALL: redirect this cycle (flush, pc_write_en, br_sel), go to FETCH, even if haz_det=1. Branch has priority over hazard.
- if_id_flush=1 in every cycle br_taken=1, regardless of state.
- stall_cycles: +1 each cycle pc_write_en=0 while reset=1. Saturates at 2^CNT_WIDTH-1, no wrap.
- Reset asserted mid-fetch: pending branch lost, FSM returns to IDLE immediately. A late imem_ready after reset is ignored.

Test Plan:
- Reset release, imem_ready 1 cycle after each request, haz_det=0 -> state IDLE->FETCH. One pc_write_en/if_id_write_en pulse per response; br_sel=0; stall_cycles increments on non-ready cycles only.
- 3-cycle memory latency, br_taken with br_offset=0x10 in 2nd wait cycle -> flush that cycle. On ready: pc_write_en=1, br_sel=1, br_offset_out=0x10, if_id_write_en=0, pend_valid cleared.
- br_taken=1, br_offset=0xFFFFFFFE coincident with imem_ready -> same-cycle redirect, br_offset_out=0xFFFFFFFE, instruction discarded.
- haz_det=1 on response, held 4 cycles -> state STALL, imem_req=0, no PC write. Re-request on the cycle after haz_det falls.
- In STALL with haz_det=1, br_taken with offset 0x8 -> redirect and flush that cycle, next state FETCH.
- CNT_WIDTH=4, memory never ready -> stall_cycles saturates at 15. Reset pulse mid-fetch -> all outputs 0, state IDLE.
